cam_entry_alloc: RTL and testbench

Write-side entry allocator for the 32-entry flip-flop CAM, directly upstream of the 5-to-32 write decoder. It holds the per-entry valid bitmap and grants the lowest free entry on allocate requests. It releases entries on free requests. It emits a registered 5-bit write index plus strobe, which the decoder expands to the one-hot row write-enable. After reset or flush it sweeps all 32 rows, issuing clear writes so CAM key storage is zeroed.

---
 rtl/cam_pkg.sv | 16 +
 rtl/cam_find_free.sv | 23 ++
 rtl/cam_entry_alloc.sv | 158 +++++++++++++++
 tb/tb_cam_entry_alloc.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// Shared types for the flip-flop CAM write/match side.
// Row count, index width and allocator FSM states.
package cam_pkg;
  localparam int CAM_ENTRIES = 32;
  localparam int CAM_IDX_W   = 5;
  localparam int CAM_CNT_W   = 6;

  typedef logic [CAM_IDX_W-1:0]   cam_idx_t;
  typedef logic [CAM_ENTRIES-1:0] cam_vec_t;
  typedef logic [CAM_CNT_W-1:0]   cam_cnt_t;

  typedef enum logic {
    ST_SCRUB,
    ST_IDLE
  } alloc_state_t;
endpackage

// File: rtl/cam_find_free.sv
// Find-first-zero over a CAM row bitmap (lowest index wins).
// vec_i: bitmap; idx_o: lowest clear bit; found_o: any clear bit.
module cam_find_free
  import cam_pkg::*;
(
  input  cam_vec_t vec_i,
  output cam_idx_t idx_o,
  output logic     found_o
);

  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    // Scan downward so the last hit is the lowest index.
    for (int i = CAM_ENTRIES - 1; i >= 0; i--) begin
      if (!vec_i[i]) begin
        idx_o   = cam_idx_t'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cam_entry_alloc.sv
// CAM write-side allocator: valid bitmap, lowest-free grant, scrub.
// Ports: clk_i/rst_i (sync high); alloc_req_i -> alloc_gnt_o/
// alloc_idx_o (comb); free_req_i/free_idx_i release; flush_i
// invalidates + rescrubs; wr_vld_o/wr_idx_o/wr_clr_o registered
// row write; valid_o/count_o/full_o/empty_o/busy_o status; err_o
// sticky protocol error when CAM_ALLOC_ERR_EN is defined, else 0.
module cam_entry_alloc
  import cam_pkg::*;
#(
  parameter int ENTRIES = CAM_ENTRIES,
  parameter int IDX_W   = CAM_IDX_W
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               alloc_req_i,
  output logic               alloc_gnt_o,
  output logic [IDX_W-1:0]   alloc_idx_o,
  input  logic               free_req_i,
  input  logic [IDX_W-1:0]   free_idx_i,
  input  logic               flush_i,
  output logic               wr_vld_o,
  output logic [IDX_W-1:0]   wr_idx_o,
  output logic               wr_clr_o,
  output logic [ENTRIES-1:0] valid_o,
  output logic [IDX_W:0]     count_o,
  output logic               full_o,
  output logic               empty_o,
  output logic               busy_o,
  output logic               err_o
);

  alloc_state_t state_q, state_d;
  cam_idx_t     ptr_q, ptr_d;
  cam_vec_t     valid_q, valid_d;
  cam_cnt_t     count_q, count_d;
  logic         wr_vld_q, wr_vld_d;
  cam_idx_t     wr_idx_q, wr_idx_d;
  logic         wr_clr_q, wr_clr_d;

  cam_idx_t ff_idx;
  logic     ff_found;
  logic     gnt;
  logic     free_ok;
  logic     full;
  logic     busy;

  cam_find_free u_find (
    .vec_i   (valid_q),
    .idx_o   (ff_idx),
    .found_o (ff_found)
  );

  assign full = (count_q == cam_cnt_t'(CAM_ENTRIES));
  assign busy = (state_q == ST_SCRUB);

  assign gnt = alloc_req_i & ~full & ~busy
             & ~flush_i & ff_found;

  // Only a currently valid row in normal operation is released.
  assign free_ok = free_req_i & ~busy & ~flush_i
                 & valid_q[free_idx_i];

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    valid_d  = valid_q;
    count_d  = count_q;
    wr_vld_d = 1'b0;
    wr_idx_d = wr_idx_q;
    wr_clr_d = 1'b0;
    if (flush_i) begin
      state_d = ST_SCRUB;
      ptr_d   = '0;
      valid_d = '0;
      count_d = '0;
    end else begin
      unique case (state_q)
        ST_SCRUB: begin
          wr_vld_d = 1'b1;
          wr_clr_d = 1'b1;
          wr_idx_d = ptr_q;
          // Wraps to 0 after the last row.
          ptr_d    = ptr_q + 1'b1;
          if (ptr_q == cam_idx_t'(CAM_ENTRIES - 1))
            state_d = ST_IDLE;
        end
        ST_IDLE: begin
          if (gnt) begin
            valid_d[ff_idx] = 1'b1;
            wr_vld_d        = 1'b1;
            wr_idx_d        = ff_idx;
          end
          // Free index is valid, grant index is not: no overlap.
          if (free_ok)
            valid_d[free_idx_i] = 1'b0;
          count_d = count_q + cam_cnt_t'(gnt)
                  - cam_cnt_t'(free_ok);
        end
        default: state_d = ST_SCRUB;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_SCRUB;
      ptr_q    <= '0;
      valid_q  <= '0;
      count_q  <= '0;
      wr_vld_q <= 1'b0;
      wr_idx_q <= '0;
      wr_clr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      valid_q  <= valid_d;
      count_q  <= count_d;
      wr_vld_q <= wr_vld_d;
      wr_idx_q <= wr_idx_d;
      wr_clr_q <= wr_clr_d;
    end
  end

`ifdef CAM_ALLOC_ERR_EN
  logic err_q, err_d, err_ev;

  assign err_ev = (free_req_i & busy)
                | (free_req_i & ~busy & ~valid_q[free_idx_i])
                | (alloc_req_i & full);

  always_comb begin
    err_d = err_q | err_ev;
    if (flush_i)
      err_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  assign alloc_gnt_o = gnt;
  assign alloc_idx_o = ff_idx;
  assign wr_vld_o    = wr_vld_q;
  assign wr_idx_o    = wr_idx_q;
  assign wr_clr_o    = wr_clr_q;
  assign valid_o     = valid_q;
  assign count_o     = count_q;
  assign full_o      = full;
  assign empty_o     = (count_q == '0);
  assign busy_o      = busy;

endmodule

// File: tb/tb_cam_entry_alloc.sv
// Self-checking bench for cam_entry_alloc.
// Table vectors for alloc/free plus directed scrub/flush/full cases.
module tb_cam_entry_alloc;

`ifdef CAM_ALLOC_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        alloc_req;
  logic        alloc_gnt;
  logic [4:0]  alloc_idx;
  logic        free_req;
  logic [4:0]  free_idx;
  logic        flush;
  logic        wr_vld;
  logic [4:0]  wr_idx;
  logic        wr_clr;
  logic [31:0] valid;
  logic [5:0]  count;
  logic        full;
  logic        empty;
  logic        busy;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cam_entry_alloc dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .alloc_req_i (alloc_req),
    .alloc_gnt_o (alloc_gnt),
    .alloc_idx_o (alloc_idx),
    .free_req_i  (free_req),
    .free_idx_i  (free_idx),
    .flush_i     (flush),
    .wr_vld_o    (wr_vld),
    .wr_idx_o    (wr_idx),
    .wr_clr_o    (wr_clr),
    .valid_o     (valid),
    .count_o     (count),
    .full_o      (full),
    .empty_o     (empty),
    .busy_o      (busy),
    .err_o       (err)
  );

  typedef struct {
    logic       a;
    logic       f;
    logic [4:0] fi;
    logic       gnt;
    logic [4:0] aidx;
    logic       wv;
    logic [4:0] wi;
    logic [5:0] cnt;
  } vec_t;

  vec_t vt[7];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // Drive one cycle; check comb grant before the edge.
  task automatic cyc(input logic a, input logic f,
                     input logic [4:0] fi, input logic fl,
                     input logic eg, input logic [4:0] ei,
                     input string nm);
    alloc_req = a;
    free_req  = f;
    free_idx  = fi;
    flush     = fl;
    #1;
    chk({nm, ".gnt"}, 32'(alloc_gnt), 32'(eg));
    if (eg) chk({nm, ".aidx"}, 32'(alloc_idx), 32'(ei));
    @(posedge clk);
    #1;
    alloc_req = 1'b0;
    free_req  = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic sweep(input logic req_during);
    for (int k = 0; k < 32; k++) begin
      alloc_req = req_during;
      #1;
      if (req_during)
        chk("scrub.gnt", 32'(alloc_gnt), 32'd0);
      @(posedge clk);
      #1;
      chk("scrub.wvld", 32'(wr_vld), 32'd1);
      chk("scrub.wclr", 32'(wr_clr), 32'd1);
      chk("scrub.widx", 32'(wr_idx), 32'(k));
      chk("scrub.busy", 32'(busy), 32'(k != 31));
    end
    alloc_req = 1'b0;
  endtask

  initial begin
    vt[0] = '{1, 0, 0, 1, 0, 1, 0, 1};
    vt[1] = '{1, 0, 0, 1, 1, 1, 1, 2};
    vt[2] = '{1, 0, 0, 1, 2, 1, 2, 3};
    vt[3] = '{0, 0, 0, 0, 3, 0, 2, 3};
    vt[4] = '{0, 1, 1, 0, 3, 0, 2, 2};
    vt[5] = '{1, 0, 0, 1, 1, 1, 1, 3};
    vt[6] = '{0, 0, 0, 0, 3, 0, 1, 3};

    rst = 1'b1; alloc_req = 1'b0; free_req = 1'b0;
    free_idx = '0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.wvld",  32'(wr_vld), 32'd0);
    chk("rst.widx",  32'(wr_idx), 32'd0);
    chk("rst.wclr",  32'(wr_clr), 32'd0);
    chk("rst.valid", valid, 32'd0);
    chk("rst.count", 32'(count), 32'd0);
    chk("rst.busy",  32'(busy), 32'd1);
    chk("rst.empty", 32'(empty), 32'd1);
    chk("rst.full",  32'(full), 32'd0);
    chk("rst.err",   32'(err), 32'd0);
    alloc_req = 1'b1;
    #1;
    chk("rst.gnt", 32'(alloc_gnt), 32'd0);
    alloc_req = 1'b0;
    rst = 1'b0;

    sweep(1'b0);
    cyc(0, 0, 0, 0, 0, 0, "idle");
    chk("post.wvld",  32'(wr_vld), 32'd0);
    chk("post.valid", valid, 32'd0);
    chk("post.empty", 32'(empty), 32'd1);

    for (int i = 0; i < 7; i++) begin
      cyc(vt[i].a, vt[i].f, vt[i].fi, 0,
          vt[i].gnt, vt[i].aidx, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d.wvld", i),
          32'(wr_vld), 32'(vt[i].wv));
      chk($sformatf("vec%0d.widx", i),
          32'(wr_idx), 32'(vt[i].wi));
      chk($sformatf("vec%0d.cnt", i),
          32'(count), 32'(vt[i].cnt));
      if (vt[i].wv)
        chk($sformatf("vec%0d.wclr", i),
            32'(wr_clr), 32'd0);
    end
    chk("vec.valid", valid, 32'h7);
    chk("vec.err", 32'(err), 32'd0);

    for (int i = 3; i < 32; i++)
      cyc(1, 0, 0, 0, 1, 5'(i), "fill");
    chk("fill.full",  32'(full), 32'd1);
    chk("fill.cnt",   32'(count), 32'd32);
    chk("fill.valid", valid, 32'hFFFF_FFFF);

    cyc(1, 0, 0, 0, 0, 0, "a33");
    chk("a33.wvld", 32'(wr_vld), 32'd0);
    chk("a33.cnt",  32'(count), 32'd32);
    chk("a33.err",  32'(err), 32'(ERR_EN));

    cyc(1, 1, 7, 0, 0, 0, "fullfa");
    chk("fullfa.cnt",   32'(count), 32'd31);
    chk("fullfa.valid", valid, 32'hFFFF_FF7F);
    chk("fullfa.wvld",  32'(wr_vld), 32'd0);
    cyc(1, 0, 0, 0, 1, 7, "re7");
    chk("re7.cnt",  32'(count), 32'd32);
    chk("re7.widx", 32'(wr_idx), 32'd7);

    for (int i = 10; i < 32; i++)
      cyc(0, 1, 5'(i), 0, 0, 0, "drain");
    chk("drain.cnt",   32'(count), 32'd10);
    chk("drain.valid", valid, 32'h3FF);

    cyc(1, 0, 0, 1, 0, 0, "flush");
    chk("flush.cnt",   32'(count), 32'd0);
    chk("flush.valid", valid, 32'd0);
    chk("flush.busy",  32'(busy), 32'd1);
    chk("flush.err",   32'(err), 32'd0);
    sweep(1'b1);

    cyc(0, 1, 5, 0, 0, 0, "inv5");
    chk("inv5.cnt", 32'(count), 32'd0);
    chk("inv5.err", 32'(err), 32'(ERR_EN));
    repeat (3) cyc(0, 0, 0, 0, 0, 0, "hold");
    chk("hold.err", 32'(err), 32'(ERR_EN));
    cyc(0, 0, 0, 1, 0, 0, "flush2");
    chk("flush2.err",  32'(err), 32'd0);
    chk("flush2.busy", 32'(busy), 32'd1);
    sweep(1'b0);
    cyc(1, 0, 0, 0, 1, 0, "last");
    chk("last.cnt", 32'(count), 32'd1);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
